// File: rtl/dkong_input_cond.sv
`default_nettype none
// ============================================================================
// Module   : dkong_input_cond
// Brief    : Player-input conditioner. It registers the joystick inputs,
//            restricts each stick to four ways, and shapes the coin request
//            into one pulse followed by a lockout gap. All outputs are
//            active-low.
// Revision : 1.0  initial release
// ============================================================================
module dkong_input_cond #(
    parameter int TICK_DIV   = 24576,
    parameter int COIN_PULSE = 100,
    parameter int COIN_GAP   = 50
) (
    input  logic       I_CLK_24576M,
    input  logic       I_RESETn,
    input  logic       I_FOURWAY,
    input  logic [4:0] I_JOY1,
    input  logic [4:0] I_JOY2,
    input  logic       I_START1,
    input  logic       I_START2,
    input  logic       I_COIN,
    output logic       O_U1,
    output logic       O_D1,
    output logic       O_L1,
    output logic       O_R1,
    output logic       O_J1,
    output logic       O_U2,
    output logic       O_D2,
    output logic       O_L2,
    output logic       O_R2,
    output logic       O_J2,
    output logic       O_S1,
    output logic       O_S2,
    output logic       O_C1
);

    localparam int PRE_W   = $clog2(TICK_DIV);
    localparam int CNT_MAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PULSE = CNT_W'(COIN_PULSE);
    localparam logic [CNT_W-1:0] CNT_GAP   = CNT_W'(COIN_GAP);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {DIR_NONE, DIR_U, DIR_D, DIR_L, DIR_R} dir_t;
    typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_GAP} coin_st_t;

    logic             fourway_r_q, fourway_r_d;
    logic [1:0]       start_r_q, start_r_d;
    logic             coin_r_q, coin_r_d;
    logic             coin_prev_q, coin_prev_d;
    logic [1:0]       start_n_q, start_n_d;
    logic             c1_q, c1_d;
    coin_st_t         state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             coin_edge;
    logic [1:0][4:0]  pad_n;

    // Per-player stick: {fire, up, down, left, right}
    for (genvar p = 0; p < 2; p++) begin : g_player
        logic [4:0] joy_in, joy_r_q, joy_r_d, out_q, out_d;
        logic       up, dn, lf, rt, vert, horz;
        logic       prev_vert_q, prev_vert_d, prev_horz_q, prev_horz_d;
        dir_t       dir_q, dir_d, vdir, hdir;

        assign joy_in = (p == 0) ? I_JOY1 : I_JOY2;

        always_comb begin
            joy_r_d     = joy_in;
            up          = joy_r_q[3] & ~joy_r_q[2];
            dn          = joy_r_q[2] & ~joy_r_q[3];
            lf          = joy_r_q[1] & ~joy_r_q[0];
            rt          = joy_r_q[0] & ~joy_r_q[1];
            vert        = up | dn;
            horz        = lf | rt;
            prev_vert_d = vert;
            prev_horz_d = horz;
            vdir        = up ? DIR_U : DIR_D;
            hdir        = lf ? DIR_L : DIR_R;
            dir_d       = DIR_NONE;
            if (vert && horz) begin
                // Diagonal: hold an already-valid direction, else favour the
                // newly pressed axis, with vertical winning ties for ladders.
                if (dir_q == vdir || dir_q == hdir)
                    dir_d = dir_q;
                else if (!prev_vert_q)
                    dir_d = vdir;
                else if (!prev_horz_q)
                    dir_d = hdir;
                else
                    dir_d = vdir;
            end else if (vert) begin
                dir_d = vdir;
            end else if (horz) begin
                dir_d = hdir;
            end
            out_d[4] = ~joy_r_q[4];
            if (fourway_r_q)
                out_d[3:0] = ~{dir_d == DIR_U, dir_d == DIR_D,
                               dir_d == DIR_L, dir_d == DIR_R};
            else
                out_d[3:0] = ~{up, dn, lf, rt};
        end

        always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
            if (!I_RESETn) begin
                joy_r_q     <= '0;
                out_q       <= '1;
                dir_q       <= DIR_NONE;
                prev_vert_q <= 1'b0;
                prev_horz_q <= 1'b0;
            end else begin
                joy_r_q     <= joy_r_d;
                out_q       <= out_d;
                dir_q       <= dir_d;
                prev_vert_q <= prev_vert_d;
                prev_horz_q <= prev_horz_d;
            end
        end

        assign pad_n[p] = out_q;
    end

    always_comb begin
        fourway_r_d = I_FOURWAY;
        start_r_d   = {I_START2, I_START1};
        coin_r_d    = I_COIN;
        start_n_d   = ~start_r_q;
        coin_edge   = coin_r_q & ~coin_prev_q;
        coin_prev_d = coin_r_q;
        state_d     = state_q;
        pre_d       = pre_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (coin_edge) begin
                    state_d = ST_PULSE;
                    pre_d   = '0;
                    cnt_d   = CNT_PULSE;
                end
            end
            ST_PULSE, ST_GAP: begin
                if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = (state_q == ST_PULSE) ? ST_GAP : ST_IDLE;
                        cnt_d   = (state_q == ST_PULSE) ? CNT_GAP : '0;
                    end
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        c1_d = (state_d != ST_PULSE);
    end

    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            fourway_r_q <= 1'b0;
            start_r_q   <= '0;
            coin_r_q    <= 1'b0;
            coin_prev_q <= 1'b0;
            start_n_q   <= '1;
            c1_q        <= 1'b1;
            state_q     <= ST_IDLE;
            pre_q       <= '0;
            cnt_q       <= '0;
        end else begin
            fourway_r_q <= fourway_r_d;
            start_r_q   <= start_r_d;
            coin_r_q    <= coin_r_d;
            coin_prev_q <= coin_prev_d;
            start_n_q   <= start_n_d;
            c1_q        <= c1_d;
            state_q     <= state_d;
            pre_q       <= pre_d;
            cnt_q       <= cnt_d;
        end
    end

    assign O_J1 = pad_n[0][4];
    assign O_U1 = pad_n[0][3];
    assign O_D1 = pad_n[0][2];
    assign O_L1 = pad_n[0][1];
    assign O_R1 = pad_n[0][0];
    assign O_J2 = pad_n[1][4];
    assign O_U2 = pad_n[1][3];
    assign O_D2 = pad_n[1][2];
    assign O_L2 = pad_n[1][1];
    assign O_R2 = pad_n[1][0];
    assign O_S1 = start_n_q[0];
    assign O_S2 = start_n_q[1];
    assign O_C1 = c1_q;

endmodule
`default_nettype wire

// File: tb/tb_dkong_input_cond.sv
`default_nettype none
// ============================================================================
// Module   : tb_dkong_input_cond
// Brief    : Self-checking bench for dkong_input_cond. It uses directed
//            vectors, coin sequences and random stimulus against a reference
//            model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dkong_input_cond;

    localparam int TD = 4;
    localparam int CP = 3;
    localparam int CG = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fourway = 1'b0;
    logic [4:0] joy1 = '0;
    logic [4:0] joy2 = '0;
    logic       st1 = 1'b0;
    logic       st2 = 1'b0;
    logic       coin = 1'b0;
    logic       o_u1, o_d1, o_l1, o_r1, o_j1, o_u2, o_d2, o_l2, o_r2, o_j2;
    logic       o_s1, o_s2, o_c1;
    logic [12:0] outs;

    always #5 clk = ~clk;

    dkong_input_cond #(.TICK_DIV(TD), .COIN_PULSE(CP), .COIN_GAP(CG)) dut (
        .I_CLK_24576M(clk), .I_RESETn(rst_n), .I_FOURWAY(fourway),
        .I_JOY1(joy1), .I_JOY2(joy2), .I_START1(st1), .I_START2(st2),
        .I_COIN(coin),
        .O_U1(o_u1), .O_D1(o_d1), .O_L1(o_l1), .O_R1(o_r1), .O_J1(o_j1),
        .O_U2(o_u2), .O_D2(o_d2), .O_L2(o_l2), .O_R2(o_r2), .O_J2(o_j2),
        .O_S1(o_s1), .O_S2(o_s2), .O_C1(o_c1)
    );

    assign outs = {o_u1, o_d1, o_l1, o_r1, o_j1, o_u2, o_d2, o_l2, o_r2, o_j2,
                   o_s1, o_s2, o_c1};

    int checks = 0;
    int failures = 0;

    // Reference model: per-player direction as an int (0 none,1 U,2 D,3 L,4 R)
    int          n;
    int          mdir [2];
    bit          mpv [2];
    bit          mph [2];
    bit          mcoin_prev;
    int          ready, ps, pe;
    logic [11:0] expj [4];
    logic        last_c1;

    task automatic chk(input string nm, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", nm, got, exp);
        end
    endtask

    function automatic int next_dir(input int cur, input bit u, input bit d,
                                    input bit l, input bit r, input bit pv, input bit ph);
        int vd, hd;
        vd = u ? 1 : (d ? 2 : 0);
        hd = l ? 3 : (r ? 4 : 0);
        if (vd == 0) return hd;
        if (hd == 0) return vd;
        if (cur == vd || cur == hd) return cur;
        if (!pv) return vd;
        if (!ph) return hd;
        return vd;
    endfunction

    task automatic model_reset();
        n = 0;
        for (int p = 0; p < 2; p++) begin
            mdir[p] = 0; mpv[p] = 0; mph[p] = 0;
        end
        mcoin_prev = 0; ready = 0; ps = 0; pe = 0;
        for (int i = 0; i < 4; i++) expj[i] = '1;
    endtask

    task automatic model_apply(input bit fw, input logic [4:0] a, input logic [4:0] b,
                               input bit s1, input bit s2, input bit c);
        logic [4:0] joy;
        logic [4:0] pl [2];
        bit u, d, l, r;
        int nd;
        for (int p = 0; p < 2; p++) begin
            joy = (p == 0) ? a : b;
            u = joy[3] && !joy[2];
            d = joy[2] && !joy[3];
            l = joy[1] && !joy[0];
            r = joy[0] && !joy[1];
            nd = next_dir(mdir[p], u, d, l, r, mpv[p], mph[p]);
            mdir[p] = nd; mpv[p] = u || d; mph[p] = l || r;
            if (fw) pl[p][4:1] = {nd != 1, nd != 2, nd != 3, nd != 4};
            else    pl[p][4:1] = {!u, !d, !l, !r};
            pl[p][0] = !joy[4];
        end
        // reorder to {U,D,L,R,J}
        expj[(n + 2) % 4] = {pl[0][4:1], pl[0][0], pl[1][4:1], pl[1][0], !s1, !s2};
        if (c && !mcoin_prev && n >= ready) begin
            ps = n + 2;
            pe = ps + CP * TD;
            ready = n + 1 + (CP + CG) * TD;
        end
        mcoin_prev = c;
    endtask

    // Entered and left on a falling edge; checks outputs, then drives one cycle.
    task automatic step(input bit fw, input logic [4:0] a, input logic [4:0] b,
                        input bit s1, input bit s2, input bit c);
        logic [12:0] e;
        e = {expj[n % 4], !(n >= ps && n < pe)};
        chk($sformatf("model_m%0d", n), outs, e);
        last_c1 = o_c1;
        fourway = fw; joy1 = a; joy2 = b; st1 = s1; st2 = s2; coin = c;
        model_apply(fw, a, b, s1, s2, c);
        n++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input bit fw, input logic [4:0] a, input logic [4:0] b,
                            input bit s1, input bit s2, input bit c);
        #2 rst_n = 1'b0;
        fourway = fw; joy1 = a; joy2 = b; st1 = s1; st2 = s2; coin = c;
        #1 chk("reset_outs", outs, 13'h1FFF);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic        fw;
        logic [4:0]  j1;
        logic [4:0]  j2;
        logic        s1;
        logic        s2;
        int          hold;
        logic [12:0] exp;
        string       nm;
    } vec_t;

    vec_t tbl [14];
    int   lows, falls;

    initial begin
        tbl[0]  = '{1, 5'b01000, 5'b00000, 0, 0, 3,  13'b0111111111111, "up"};
        tbl[1]  = '{1, 5'b00000, 5'b00000, 0, 0, 3,  13'b1111111111111, "up_release"};
        tbl[2]  = '{1, 5'b00001, 5'b00000, 0, 0, 10, 13'b1110111111111, "right_hold"};
        tbl[3]  = '{1, 5'b01001, 5'b00000, 0, 0, 10, 13'b1110111111111, "diag_keep_right"};
        tbl[4]  = '{1, 5'b01000, 5'b00000, 0, 0, 3,  13'b0111111111111, "diag_drop_right"};
        tbl[5]  = '{1, 5'b00000, 5'b00000, 0, 0, 3,  13'b1111111111111, "neutral1"};
        tbl[6]  = '{0, 5'b00001, 5'b00000, 0, 0, 3,  13'b1110111111111, "eight_right"};
        tbl[7]  = '{0, 5'b01001, 5'b00000, 0, 0, 3,  13'b0110111111111, "eight_diag"};
        tbl[8]  = '{0, 5'b00000, 5'b00000, 0, 0, 3,  13'b1111111111111, "neutral2"};
        tbl[9]  = '{1, 5'b01010, 5'b00101, 0, 0, 3,  13'b0111110111111, "new_diag_both"};
        tbl[10] = '{1, 5'b00000, 5'b00000, 0, 0, 3,  13'b1111111111111, "neutral3"};
        tbl[11] = '{1, 5'b10000, 5'b00000, 0, 1, 3,  13'b1111011111101, "fire1_start2"};
        tbl[12] = '{1, 5'b00000, 5'b01110, 0, 0, 3,  13'b1111111011111, "p2_cancel_vert"};
        tbl[13] = '{1, 5'b00000, 5'b00000, 0, 0, 3,  13'b1111111111111, "neutral4"};

        model_reset();
        @(negedge clk);

        // Everything held active through reset release
        do_reset(1, 5'b11111, 5'b11111, 1, 1, 1);
        step(1, 5'b11111, 5'b11111, 1, 1, 1);
        step(1, 5'b11111, 5'b11111, 1, 1, 1);
        chk("release_c1_low", {12'd0, o_c1}, 13'd0);
        chk("release_u1_cancel", {12'd0, o_u1}, 13'd1);
        repeat (25) step(1, 5'b11111, 5'b11111, 1, 1, 1);

        // Directed vectors
        do_reset(1, '0, '0, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            repeat (tbl[i].hold) step(tbl[i].fw, tbl[i].j1, tbl[i].j2, tbl[i].s1, tbl[i].s2, 0);
            chk(tbl[i].nm, outs, tbl[i].exp);
        end

        // Coin held for 60 cycles: exactly one pulse of CP*TD cycles
        do_reset(1, '0, '0, 0, 0, 0);
        repeat (3) step(1, '0, '0, 0, 0, 0);
        lows = 0; falls = 0;
        for (int k = 0; k < 60; k++) begin
            step(1, '0, '0, 0, 0, 1);
            if (last_c1 == 1'b0) lows++;
            if (k == 2) chk("held_first_low", {12'd0, last_c1}, 13'd0);
            if (k == 1) chk("held_pre_low", {12'd0, last_c1}, 13'd1);
        end
        chk("held_low_cycles", 13'(lows), 13'(CP * TD));
        repeat (25) step(1, '0, '0, 0, 0, 0);

        // A press during the gap is dropped; a press just after the gap is accepted
        lows = 0; falls = 0;
        for (int k = 0; k < 50; k++) begin
            step(1, '0, '0, 0, 0, (k == 0 || k == 16 || k == 22));
            if (last_c1 == 1'b0) lows++;
            if (k == 24) chk("repress_first_low", {12'd0, last_c1}, 13'd0);
        end
        chk("gap_press_lows", 13'(lows), 13'(2 * CP * TD));

        // Reset in the middle of a pulse, then a full pulse afterwards
        repeat (3) step(1, '0, '0, 0, 0, 0);
        step(1, '0, '0, 0, 0, 1);
        lows = 0;
        for (int k = 0; k < 20 && lows < 5; k++) begin
            step(1, '0, '0, 0, 0, 0);
            if (last_c1 == 1'b0) lows++;
        end
        chk("midpulse_reached", 13'(lows), 13'd5);
        do_reset(1, '0, '0, 0, 0, 0);
        step(1, '0, '0, 0, 0, 0);
        step(1, '0, '0, 0, 0, 1);
        lows = 0;
        for (int k = 0; k < 30; k++) begin
            step(1, '0, '0, 0, 0, 0);
            if (last_c1 == 1'b0) lows++;
        end
        chk("after_reset_pulse", 13'(lows), 13'(CP * TD));

        // Random stimulus against the model
        do_reset(1, '0, '0, 0, 0, 0);
        for (int k = 0; k < 200; k++) begin
            bit          rfw, rs1, rs2, rc;
            logic [4:0]  ra, rb;
            int          h;
            rfw = ($urandom_range(0, 3) != 0);
            ra  = 5'($urandom);
            rb  = 5'($urandom);
            rs1 = 1'($urandom);
            rs2 = 1'($urandom);
            rc  = ($urandom_range(0, 5) == 0);
            h   = $urandom_range(1, 4);
            repeat (h) step(rfw, ra, rb, rs1, rs2, rc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
